// File: rtl/memory_arbiter.sv
// memory_arbiter: two-client initiator serializing reads/writes onto a single-port byte memory.
// Ports:
//   Clock, Reset                   rising-edge clock, asynchronous active-high reset
//   Req0/1, We0/1, Addr0/1, WData0/1  client requests (held until AckN)
//   Ack0/1, RData0/1               one-cycle completion pulse and read data per client
//   Grant, Busy                    owner of current/last transaction, transaction in flight
//   Address, MemWrite, WriteData, ReadData  memory port
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed
// priority where client 0 always wins ties.
module memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData0,
    output logic [DATA_W-1:0] RData1,
    output logic              Grant,
    output logic              Busy,
    output logic [ADDR_W-1:0] Address,
    output logic              MemWrite,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);
    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
    state_t state_q, state_d;
    logic grant_q, grant_d, we_q, we_d, winner, sel_we, rd_done;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] writedata_q, writedata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;
    // ptr_q remembers the last winner; a tie goes to the other client
    assign winner = (Req0 & Req1) ? ~ptr_q : Req1;
`else
    assign winner = (Req0 & Req1) ? 1'b0 : Req1;
`endif
    assign sel_we = winner ? We1 : We0;
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        we_d        = we_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: if (Req0 | Req1) begin
                state_d     = ACCESS;
                grant_d     = winner;
                we_d        = sel_we;
                address_d   = winner ? Addr1 : Addr0;
                // reads present zero on WriteData during ACCESS
                writedata_d = sel_we ? (winner ? WData1 : WData0) : '0;
`ifdef ARB_ROUND_ROBIN_EN
                ptr_d       = winner;
`endif
            end
            ACCESS: state_d = COMPLETE;
            COMPLETE: begin
                state_d  = IDLE;
                rdata0_d = (!we_q && !grant_q) ? ReadData : rdata0_q;
                rdata1_d = (!we_q &&  grant_q) ? ReadData : rdata1_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            we_q        <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end
    // Synchronous-read memory returns data during COMPLETE; bypass it so RDataN is
    // already valid in the AckN cycle, then the register holds it afterwards.
    assign rd_done   = (state_q == COMPLETE) && !we_q;
    assign RData0    = (rd_done && !grant_q) ? ReadData : rdata0_q;
    assign RData1    = (rd_done &&  grant_q) ? ReadData : rdata1_q;
    assign Ack0      = (state_q == COMPLETE) && !grant_q;
    assign Ack1      = (state_q == COMPLETE) &&  grant_q;
    assign MemWrite  = (state_q == ACCESS) && we_q;
    assign Busy      = state_q != IDLE;
    assign Grant     = grant_q;
    assign Address   = address_q;
    assign WriteData = writedata_q;
endmodule
